// File: rtl/mem_stream_pkg.sv
// Shared definitions for the memory-to-stream family: scheduler state encoding
// and the default widths used by the scheduler and future streamer variants.
package mem_stream_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_START     = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_GAP       = 2'd3
    } sched_state_t;

    localparam int DEF_LEN_WIDTH   = 16;
    localparam int DEF_GAP_WIDTH   = 32;
    localparam int DEF_COUNT_WIDTH = 32;

endpackage

// File: rtl/mem_stream_scheduler.sv
// Frame scheduler for the memory-to-AXI4-Stream streamer: issues start pulses
// with a latched length, waits for done, spaces frames by a gap, stops after a burst.
module mem_stream_scheduler
    import mem_stream_pkg::*;
#(
    parameter int len_width   = DEF_LEN_WIDTH,
    parameter int gap_width   = DEF_GAP_WIDTH,
    parameter int count_width = DEF_COUNT_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cfg_enable,
    input  logic [len_width-1:0]   cfg_frame_len,
    input  logic [gap_width-1:0]   cfg_gap,
    input  logic [count_width-1:0] cfg_burst,
    output logic                   str_start,
    output logic [len_width-1:0]   str_len,
    input  logic                   str_done,
    output logic                   busy,
    output logic                   burst_done,
    output logic                   cfg_error,
    output logic [count_width-1:0] frame_count
);

    sched_state_t           state_reg, state_next;
    logic [gap_width-1:0]   gap_cnt_reg, gap_cnt_next;
    logic [count_width-1:0] frame_count_reg, frame_count_next;
    logic [count_width-1:0] count_inc;
    logic [len_width-1:0]   str_len_reg;
    logic                   burst_done_reg, burst_done_next;
    logic                   cfg_error_reg, cfg_error_next;
    logic                   busy_reg;
    logic                   burst_hit;
    logic                   len_zero;

    assign count_inc = frame_count_reg + count_width'(1);
    // Live comparison: lowering cfg_burst below the count mid-run never matches.
    assign burst_hit = (cfg_burst != '0) && (count_inc == cfg_burst);
    assign len_zero  = (cfg_frame_len == '0);

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg       <= ST_IDLE;
            gap_cnt_reg     <= '0;
            frame_count_reg <= '0;
            str_len_reg     <= '0;
            burst_done_reg  <= 1'b0;
            cfg_error_reg   <= 1'b0;
            busy_reg        <= 1'b0;
        end else begin
            state_reg       <= state_next;
            gap_cnt_reg     <= gap_cnt_next;
            frame_count_reg <= frame_count_next;
            burst_done_reg  <= burst_done_next;
            cfg_error_reg   <= cfg_error_next;
            busy_reg        <= (state_next != ST_IDLE);
            // Length is captured on the same edge that raises str_start.
            if (state_next == ST_START) begin
                str_len_reg <= cfg_frame_len;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (cfg_enable && !burst_done_reg && !len_zero) begin
                    state_next = ST_START;
                end
            end
            ST_START: begin
                state_next = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (str_done) begin
                    if (burst_hit) begin
                        state_next = ST_IDLE;
                    end else if (!cfg_enable) begin
                        state_next = ST_IDLE;
                    end else if (cfg_gap == '0) begin
                        state_next = ST_START;
                    end else begin
                        state_next = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                if (!cfg_enable) begin
                    state_next = ST_IDLE;
                end else if (gap_cnt_reg <= gap_width'(1)) begin
                    state_next = ST_START;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Counters, sticky flags and outputs
    always_comb begin
        gap_cnt_next     = gap_cnt_reg;
        frame_count_next = frame_count_reg;
        burst_done_next  = burst_done_reg;
        cfg_error_next   = cfg_error_reg;
        case (state_reg)
            ST_IDLE: begin
                if (!cfg_enable) begin
                    burst_done_next = 1'b0;
                    cfg_error_next  = 1'b0;
                end else if (!burst_done_reg) begin
                    if (len_zero) begin
                        cfg_error_next = 1'b1;
                    end else begin
                        frame_count_next = '0;
                    end
                end
            end
            ST_WAIT_DONE: begin
                if (str_done) begin
                    frame_count_next = count_inc;
                    if (burst_hit) begin
                        burst_done_next = 1'b1;
                    end else if (cfg_enable && (cfg_gap != '0)) begin
                        gap_cnt_next = cfg_gap;
                    end
                end
            end
            ST_GAP: begin
                if (!cfg_enable) begin
                    gap_cnt_next = '0;
                end else begin
                    gap_cnt_next = gap_cnt_reg - gap_width'(1);
                end
            end
            default: ;
        endcase
    end

    assign str_start   = (state_reg == ST_START);
    assign str_len     = str_len_reg;
    assign busy        = busy_reg;
    assign burst_done  = burst_done_reg;
    assign cfg_error   = cfg_error_reg;
    assign frame_count = frame_count_reg;

endmodule

// File: tb/tb_mem_stream_scheduler.sv
// Self-checking bench for mem_stream_scheduler: scenario tasks with a simple
// streamer responder and expectations derived from the frame timing rules.
module tb_mem_stream_scheduler;

    logic        clk;
    logic        rst;
    logic        cfg_enable;
    logic [15:0] cfg_frame_len;
    logic [31:0] cfg_gap;
    logic [31:0] cfg_burst;
    logic        str_start;
    logic [15:0] str_len;
    logic        str_done;
    logic        busy;
    logic        burst_done;
    logic        cfg_error;
    logic [31:0] frame_count;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    mem_stream_scheduler #(
        .len_width(16), .gap_width(32), .count_width(32)
    ) dut (
        .clk(clk), .rst(rst), .cfg_enable(cfg_enable),
        .cfg_frame_len(cfg_frame_len), .cfg_gap(cfg_gap), .cfg_burst(cfg_burst),
        .str_start(str_start), .str_len(str_len), .str_done(str_done),
        .busy(busy), .burst_done(burst_done), .cfg_error(cfg_error),
        .frame_count(frame_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; cfg_enable = 1'b0; cfg_frame_len = '0; cfg_gap = '0;
        cfg_burst = '0; str_done = 1'b0;
        tick(); tick();
        checks++;
        if ({str_start, str_len, busy, burst_done, cfg_error, frame_count} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got start=%0b len=%0d busy=%0b bd=%0b err=%0b fc=%0d, want all 0",
                     str_start, str_len, busy, burst_done, cfg_error, frame_count);
        end
        @(negedge clk); rst = 1'b1;
        tick();
        $display("reset: outputs zero during reset, released");
    endtask

    // Runs one burst, responding to each start after lat cycles; checks
    // length, start spacing (gap+1 after previous done), count and flags.
    task automatic run_burst(input logic [15:0] len, input logic [31:0] gap,
                             input logic [31:0] burst, input int lat, input string tag);
        int starts  = 0;
        int last_d  = -1;
        int done_at = -1;
        cfg_frame_len = len; cfg_gap = gap; cfg_burst = burst; cfg_enable = 1'b1;
        for (int k = 0; k < 3000 && !burst_done; k++) begin
            tick();
            str_done = 1'b0;
            if (cyc == done_at) begin
                str_done = 1'b1;
                last_d = cyc;
            end
            if (str_start) begin
                starts++;
                checks++;
                if (str_len !== len) begin
                    errors++;
                    $display("FAIL %s_str_len: got %0d want %0d", tag, str_len, len);
                end
                if (starts > 1) begin
                    checks++;
                    if (cyc - last_d != int'(gap) + 1) begin
                        errors++;
                        $display("FAIL %s_start_spacing: got %0d want %0d", tag, cyc - last_d, gap + 1);
                    end
                end
                done_at = cyc + lat;
            end
        end
        str_done = 1'b0;
        checks++;
        if (burst_done !== 1'b1 || busy !== 1'b0 || str_start !== 1'b0) begin
            errors++;
            $display("FAIL %s_end_flags: got bd=%0b busy=%0b start=%0b want 1 0 0", tag, burst_done, busy, str_start);
        end
        checks++;
        if (starts != int'(burst)) begin
            errors++;
            $display("FAIL %s_start_count: got %0d want %0d", tag, starts, burst);
        end
        checks++;
        if (frame_count !== burst) begin
            errors++;
            $display("FAIL %s_frame_count: got %0d want %0d", tag, frame_count, burst);
        end
        // Still enabled: burst_done must hold and no restart may happen.
        tick(); tick();
        checks++;
        if (burst_done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_sticky: got bd=%0b busy=%0b want 1 0", tag, burst_done, busy);
        end
        cfg_enable = 1'b0;
        tick();
        checks++;
        if (burst_done !== 1'b0) begin
            errors++;
            $display("FAIL %s_bd_clear: got %0b want 0", tag, burst_done);
        end
        $display("%s: len=%0d gap=%0d burst=%0d lat=%0d starts=%0d", tag, len, gap, burst, lat, starts);
    endtask

    task automatic test_basic();
        run_burst(16'd64, 32'd0, 32'd3, 10, "basic");
    endtask

    task automatic test_gap();
        run_burst(16'd100, 32'd5, 32'd2, 4, "gap");
    endtask

    task automatic test_random_bursts();
        for (int i = 0; i < 6; i++) begin
            run_burst(16'($urandom_range(1, 65535)), 32'($urandom_range(0, 7)),
                      32'($urandom_range(1, 4)), int'($urandom_range(1, 6)), "random");
        end
    endtask

    task automatic wait_start(input string tag, output int s);
        s = -1;
        for (int k = 0; k < 50 && s < 0; k++) begin
            tick();
            if (str_start) s = cyc;
        end
        checks++;
        if (s < 0) begin
            errors++;
            $display("FAIL %s_wait_start: got no str_start want one within 50 cycles", tag);
        end
    endtask

    task automatic test_disable_mid_frame();
        int s;
        int extra = 0;
        cfg_frame_len = 16'd32; cfg_gap = '0; cfg_burst = '0; cfg_enable = 1'b1;
        wait_start("disable", s);
        for (int k = 0; k < 30; k++) begin
            tick();
            str_done = (cyc == s + 6);
            if (cyc == s + 3) cfg_enable = 1'b0;
            if (str_start) extra++;
        end
        str_done = 1'b0;
        checks++;
        if (extra != 0 || frame_count !== 32'd1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL disable_mid_frame: got extra=%0d fc=%0d busy=%0b want 0 1 0", extra, frame_count, busy);
        end
        $display("disable_mid_frame: extra_starts=%0d frame_count=%0d", extra, frame_count);
    endtask

    task automatic test_zero_len();
        int starts = 0;
        int s;
        cfg_frame_len = '0; cfg_gap = '0; cfg_burst = '0; cfg_enable = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (str_start) starts++;
        end
        checks++;
        if (cfg_error !== 1'b1 || starts != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_len_error: got err=%0b starts=%0d busy=%0b want 1 0 0", cfg_error, starts, busy);
        end
        cfg_enable = 1'b0;
        tick();
        checks++;
        if (cfg_error !== 1'b0) begin
            errors++;
            $display("FAIL zero_len_clear: got %0b want 0", cfg_error);
        end
        cfg_frame_len = 16'd8; cfg_enable = 1'b1;
        wait_start("zero_len", s);
        checks++;
        if (str_len !== 16'd8 || cfg_error !== 1'b0) begin
            errors++;
            $display("FAIL zero_len_restart: got len=%0d err=%0b want 8 0", str_len, cfg_error);
        end
        cfg_enable = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            str_done = (cyc == s + 2);
        end
        str_done = 1'b0;
        $display("zero_len: error raised, cleared, restarted with len=%0d", str_len);
    endtask

    task automatic test_spurious_done();
        int s;
        int s2 = -1;
        cfg_frame_len = 16'd16; cfg_gap = 32'd8; cfg_burst = '0; cfg_enable = 1'b1;
        wait_start("spurious", s);
        // Real done at s+2, then a stray done three cycles into the gap.
        for (int k = 0; k < 30 && s2 < 0; k++) begin
            tick();
            str_done = (cyc == s + 2) || (cyc == s + 5);
            if (str_start) s2 = cyc;
            if (cyc == s + 6) begin
                checks++;
                if (busy !== 1'b1 || frame_count !== 32'd1) begin
                    errors++;
                    $display("FAIL spurious_gap_state: got busy=%0b fc=%0d want 1 1", busy, frame_count);
                end
            end
        end
        str_done = 1'b0;
        checks++;
        if (s2 != s + 2 + 9 || frame_count !== 32'd1) begin
            errors++;
            $display("FAIL spurious_gap: got next_start_delta=%0d fc=%0d want 11 1", s2 - s, frame_count);
        end
        cfg_enable = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            str_done = (cyc == s2 + 2);
        end
        str_done = 1'b1;
        tick();
        str_done = 1'b0;
        tick();
        checks++;
        if (frame_count !== 32'd2 || busy !== 1'b0 || str_start !== 1'b0) begin
            errors++;
            $display("FAIL spurious_idle: got fc=%0d busy=%0b start=%0b want 2 0 0", frame_count, busy, str_start);
        end
        $display("spurious_done: frame_count=%0d after stray dones", frame_count);
    endtask

    task automatic test_async_reset();
        int s;
        cfg_frame_len = 16'd40; cfg_gap = '0; cfg_burst = '0; cfg_enable = 1'b1;
        wait_start("areset", s);
        for (int k = 0; k < 3; k++) begin
            tick();
            str_done = (cyc == s + 1);
        end
        str_done = 1'b0;
        checks++;
        if (busy !== 1'b1 || frame_count !== 32'd1) begin
            errors++;
            $display("FAIL areset_pre: got busy=%0b fc=%0d want 1 1", busy, frame_count);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({str_start, str_len, busy, burst_done, cfg_error, frame_count} !== '0) begin
            errors++;
            $display("FAIL areset_immediate: got start=%0b len=%0d busy=%0b fc=%0d want all 0",
                     str_start, str_len, busy, frame_count);
        end
        @(negedge clk); rst = 1'b1;
        tick();
        checks++;
        if (str_start !== 1'b1 || frame_count !== 32'd0 || str_len !== 16'd40) begin
            errors++;
            $display("FAIL areset_restart: got start=%0b fc=%0d len=%0d want 1 0 40", str_start, frame_count, str_len);
        end
        cfg_enable = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            str_done = (k == 1);
        end
        str_done = 1'b0;
        $display("async_reset: cleared mid-frame and restarted on first edge");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gap();
        test_random_bursts();
        test_disable_mid_frame();
        test_zero_len();
        test_spurious_done();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
